// File: rtl/rpc_trx_sched_pkg.sv
// rtl/rpc_trx_sched_pkg.sv - shared types and chunk helper for the RPC transaction scheduler
// Purpose: command opcodes, scheduler state encoding and the page-chunk length function.
// Ports: none (package).
package rpc_trx_sched_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ACT = 3'd1,
    OP_WR  = 3'd2,
    OP_RD  = 3'd3,
    OP_PRE = 3'd4,
    OP_REF = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT,
    ST_XFER,
    ST_PRE,
    ST_REF
  } sched_state_e;

  // Words that can be moved before the burst runs off the end of the open page.
  function automatic logic [31:0] chunk_words(input logic [31:0] rem,
                                              input logic [31:0] col_off,
                                              input int unsigned col_width);
    logic [31:0] room;
    room = (32'd1 << col_width) - col_off;
    return (rem < room) ? rem : room;
  endfunction

endpackage

// File: rtl/rpc_ref_timer.sv
// rtl/rpc_ref_timer.sv - periodic refresh request timer with missed-refresh flag
// Purpose: free-running down-counter that raises ref_pending_o every RefreshInterval cycles.
// Ports: clk_i, rst_i (sync, active-high); ref_ack_i = REF command handshake;
//        ref_pending_o = refresh owed; ref_err_o = sticky, interval expired while still owed.
module rpc_ref_timer #(
  parameter int RefreshInterval = 780
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ref_ack_i,
  output logic ref_pending_o,
  output logic ref_err_o
);

  localparam int CntWidth = $clog2(RefreshInterval);
  localparam logic [CntWidth-1:0] Reload = CntWidth'(RefreshInterval - 1);

  logic [CntWidth-1:0] cnt;
  logic                expire;

  assign expire = (cnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt           <= Reload;
      ref_pending_o <= 1'b0;
      ref_err_o     <= 1'b0;
    end else begin
      cnt <= expire ? Reload : cnt - CntWidth'(1);
      // A new expiry outranks an acknowledge landing in the same cycle.
      if (expire) begin
        ref_pending_o <= 1'b1;
      end else if (ref_ack_i) begin
        ref_pending_o <= 1'b0;
      end
      if (expire && ref_pending_o && !ref_ack_i) begin
        ref_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpc_trx_scheduler.sv
// rtl/rpc_trx_scheduler.sv - sequences DRAM transactions into RPC ACT/WR/RD/PRE/REF commands
// Purpose: splits bursts at page boundaries, wraps each chunk in ACT/PRE, inserts REF
//          while idle or after a PRE.
// Ports: clk_i, rst_i (sync, active-high);
//        trx_valid_i/trx_ready_o/trx_is_write_i/trx_addr_i/trx_len_i : transaction input;
//        cmd_valid_o/cmd_ready_i/cmd_op_o/cmd_addr_o/cmd_len_o      : registered PHY command;
//        busy_o (not idle); ref_err_o (sticky missed refresh).
module rpc_trx_scheduler
  import rpc_trx_sched_pkg::*;
#(
  parameter int DramAddrWidth   = 20,
  parameter int DramLenWidth    = 6,
  parameter int ColWidth        = 5,
  parameter int RefreshInterval = 780
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trx_valid_i,
  output logic                     trx_ready_o,
  input  logic                     trx_is_write_i,
  input  logic [DramAddrWidth-1:0] trx_addr_i,
  input  logic [DramLenWidth-1:0]  trx_len_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [2:0]               cmd_op_o,
  output logic [DramAddrWidth-1:0] cmd_addr_o,
  output logic [DramLenWidth-1:0]  cmd_len_o,
  output logic                     busy_o,
  output logic                     ref_err_o
);

  sched_state_e              state, state_next;
  logic [DramAddrWidth-1:0]  addr, addr_next;
  logic [DramLenWidth:0]     rem, rem_next, chunk;
  logic                      is_write, is_write_next;
  logic                      resume, resume_next;
  logic                      out_en;
  logic                      cmd_ack, ref_ack, ref_pending;
  logic                      cmd_valid_next;
  cmd_op_e                   op_next;
  logic [DramAddrWidth-1:0]  cmd_addr_next;
  logic [DramLenWidth-1:0]   cmd_len_next;

  assign chunk   = (DramLenWidth+1)'(chunk_words(32'(rem), 32'(addr[ColWidth-1:0]), ColWidth));
  assign cmd_ack = cmd_valid_o & cmd_ready_i;
  assign ref_ack = cmd_ack & (state == ST_REF);
  // out_en keeps ready low in the first cycle after reset so every output starts at 0.
  assign trx_ready_o = out_en & (state == ST_IDLE) & ~ref_pending;
  assign busy_o      = (state != ST_IDLE);

  rpc_ref_timer #(
    .RefreshInterval(RefreshInterval)
  ) u_ref_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ref_ack_i    (ref_ack),
    .ref_pending_o(ref_pending),
    .ref_err_o    (ref_err_o)
  );

  always_comb begin
    state_next    = state;
    addr_next     = addr;
    rem_next      = rem;
    is_write_next = is_write;
    resume_next   = resume;
    case (state)
      ST_IDLE: begin
        if (ref_pending) begin
          state_next  = ST_REF;
          resume_next = 1'b0;
        end else if (trx_valid_i && trx_ready_o) begin
          addr_next     = trx_addr_i;
          is_write_next = trx_is_write_i;
          rem_next      = (DramLenWidth+1)'(trx_len_i) + (DramLenWidth+1)'(1);
          state_next    = ST_ACT;
        end
      end
      ST_ACT: if (cmd_ack) state_next = ST_XFER;
      ST_XFER: begin
        if (cmd_ack) begin
          addr_next  = addr + DramAddrWidth'(chunk);
          rem_next   = rem - chunk;
          state_next = ST_PRE;
        end
      end
      ST_PRE: begin
        if (cmd_ack) begin
          if (ref_pending) begin
            state_next  = ST_REF;
            resume_next = (rem != '0);
          end else if (rem != '0) begin
            state_next = ST_ACT;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_REF: if (cmd_ack) state_next = resume ? ST_ACT : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next command is decoded from the next state so cmd_* come straight from flops.
  // addr/rem are untouched between ACT and XFER, so chunk is already valid for XFER.
  always_comb begin
    cmd_valid_next = (state_next != ST_IDLE);
    op_next        = OP_NOP;
    cmd_addr_next  = '0;
    cmd_len_next   = '0;
    case (state_next)
      ST_ACT: begin
        op_next       = OP_ACT;
        cmd_addr_next = {addr_next[DramAddrWidth-1:ColWidth], {ColWidth{1'b0}}};
      end
      ST_XFER: begin
        op_next       = is_write_next ? OP_WR : OP_RD;
        cmd_addr_next = addr_next;
        cmd_len_next  = DramLenWidth'(chunk - (DramLenWidth+1)'(1));
      end
      ST_PRE:  op_next = OP_PRE;
      ST_REF:  op_next = OP_REF;
      default: op_next = OP_NOP;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      addr        <= '0;
      rem         <= '0;
      is_write    <= 1'b0;
      resume      <= 1'b0;
      out_en      <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_op_o    <= OP_NOP;
      cmd_addr_o  <= '0;
      cmd_len_o   <= '0;
    end else begin
      state       <= state_next;
      addr        <= addr_next;
      rem         <= rem_next;
      is_write    <= is_write_next;
      resume      <= resume_next;
      out_en      <= 1'b1;
      cmd_valid_o <= cmd_valid_next;
      cmd_op_o    <= op_next;
      cmd_addr_o  <= cmd_addr_next;
      cmd_len_o   <= cmd_len_next;
    end
  end

endmodule

// File: tb/tb_rpc_trx_scheduler.sv
// tb/tb_rpc_trx_scheduler.sv - self-checking bench for rpc_trx_scheduler
module tb_rpc_trx_scheduler;
  import rpc_trx_sched_pkg::*;

  localparam int AW = 20;
  localparam int LW = 6;
  localparam int CW = 5;
  localparam int RI = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trx_valid = 1'b0;
  logic          trx_ready;
  logic          trx_is_write = 1'b0;
  logic [AW-1:0] trx_addr = '0;
  logic [LW-1:0] trx_len = '0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b1;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          busy;
  logic          ref_err;

  always #5 clk = ~clk;

  rpc_trx_scheduler #(
    .DramAddrWidth(AW), .DramLenWidth(LW), .ColWidth(CW), .RefreshInterval(RI)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .trx_valid_i(trx_valid), .trx_ready_o(trx_ready), .trx_is_write_i(trx_is_write),
    .trx_addr_i(trx_addr), .trx_len_i(trx_len),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_op_o(cmd_op),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .busy_o(busy), .ref_err_o(ref_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [28:0] cmd_pack(input logic [2:0] op, input logic [AW-1:0] a,
                                           input logic [LW-1:0] l);
    return {op, a, l};
  endfunction

  // Reference model: commands still owed for the current transaction, whether a REF
  // must come next, and the refresh bookkeeping derived from the cycle count.
  logic [28:0] exp_q[$];
  logic [28:0] log_q[$];
  logic [28:0] want_q[$];
  bit          ref_due = 0;
  bit          pending_m = 0;
  bit          err_m = 0;
  bit          fresh = 1;
  int          k = 0;

  always @(negedge clk) begin
    logic [28:0]   head;
    logic [AW-1:0] a;
    bit            idle_m, exp_ready, ack, ref_ack;
    int            rem, off, ch;
    idle_m    = (exp_q.size() == 0) && !ref_due;
    exp_ready = idle_m && !pending_m && !fresh;
    check_eq("trx_ready", 32'(trx_ready), 32'(exp_ready));
    check_eq("busy", 32'(busy), 32'(!idle_m));
    check_eq("cmd_valid", 32'(cmd_valid), 32'(!idle_m));
    check_eq("ref_err", 32'(ref_err), 32'(err_m));
    if (cmd_valid && !idle_m) begin
      head = ref_due ? cmd_pack(OP_REF, '0, '0) : exp_q[0];
      check_eq("cmd", 32'({cmd_op, cmd_addr, cmd_len}), 32'(head));
    end
    if (fresh) check_eq("reset_cmd", 32'({cmd_op, cmd_addr, cmd_len}), 32'(0));

    ack = cmd_valid && cmd_ready;
    if (rst) begin
      exp_q.delete();
      ref_due = 0; pending_m = 0; err_m = 0; fresh = 1; k = 0;
    end else begin
      fresh   = 0;
      ref_ack = ack && ref_due;
      if (ack && !idle_m) begin
        log_q.push_back({cmd_op, cmd_addr, cmd_len});
        if (ref_due) begin
          ref_due = 0;
        end else begin
          head = exp_q.pop_front();
          if (head[28:26] == OP_PRE && pending_m) ref_due = 1;
        end
      end else if (idle_m && pending_m) begin
        ref_due = 1;
      end
      if (exp_ready && trx_valid) begin
        a   = trx_addr;
        rem = int'(trx_len) + 1;
        while (rem > 0) begin
          off = int'(a[CW-1:0]);
          ch  = (rem < (1 << CW) - off) ? rem : (1 << CW) - off;
          exp_q.push_back(cmd_pack(OP_ACT, {a[AW-1:CW], {CW{1'b0}}}, '0));
          exp_q.push_back(cmd_pack(trx_is_write ? OP_WR : OP_RD, a, LW'(ch - 1)));
          exp_q.push_back(cmd_pack(OP_PRE, '0, '0));
          a   = a + AW'(ch);
          rem = rem - ch;
        end
      end
      k++;
      if (k % RI == 0) begin
        if (pending_m && !ref_ack) err_m = 1;
        pending_m = 1;
      end else if (ref_ack) begin
        pending_m = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; trx_valid = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    log_q.delete();
    want_q.delete();
  endtask

  task automatic send(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit ok;
    trx_is_write = w; trx_addr = a; trx_len = l; trx_valid = 1'b1; ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = trx_ready;
      @(posedge clk);
    end
    #1 trx_valid = 1'b0;
    check_eq("accept_timeout", 32'(ok), 32'(1));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    check_eq("idle_timeout", 32'(idle), 32'(1));
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_count"}, 32'(log_q.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(want_q[i]));
  endtask

  initial begin
    // Single-chunk read: latency and return to idle at N+4.
    do_reset();
    send(1'b0, 20'h00040, 6'd3);
    check_eq("t1_act_valid", 32'(cmd_valid), 32'(1));
    check_eq("t1_act_op", 32'(cmd_op), 32'(OP_ACT));
    repeat (2) @(posedge clk);
    #1 check_eq("t1_busy_n3", 32'(busy), 32'(1));
    @(posedge clk);
    #1 check_eq("t1_busy_n4", 32'(busy), 32'(0));
    want_q = '{cmd_pack(OP_ACT, 20'h00040, 0), cmd_pack(OP_RD, 20'h00040, 3), cmd_pack(OP_PRE, 0, 0)};
    check_log("t1");

    // Write split across a page boundary.
    do_reset();
    send(1'b1, 20'h0001C, 6'd9);
    wait_idle();
    want_q = '{cmd_pack(OP_ACT, 20'h00000, 0), cmd_pack(OP_WR, 20'h0001C, 3), cmd_pack(OP_PRE, 0, 0),
               cmd_pack(OP_ACT, 20'h00020, 0), cmd_pack(OP_WR, 20'h00020, 5), cmd_pack(OP_PRE, 0, 0)};
    check_log("t2");

    // Maximum-length read: two full pages.
    do_reset();
    send(1'b0, 20'h00000, 6'd63);
    wait_idle();
    want_q = '{cmd_pack(OP_ACT, 20'h00000, 0), cmd_pack(OP_RD, 20'h00000, 31), cmd_pack(OP_PRE, 0, 0),
               cmd_pack(OP_ACT, 20'h00020, 0), cmd_pack(OP_RD, 20'h00020, 31), cmd_pack(OP_PRE, 0, 0)};
    check_log("t3");

    // Refresh expires during the first XFER: accept at cycle 14, expiry at 16.
    do_reset();
    repeat (13) @(posedge clk);
    #1 send(1'b1, 20'h0001C, 6'd9);
    wait_idle();
    want_q = '{cmd_pack(OP_ACT, 20'h00000, 0), cmd_pack(OP_WR, 20'h0001C, 3), cmd_pack(OP_PRE, 0, 0),
               cmd_pack(OP_REF, 0, 0),
               cmd_pack(OP_ACT, 20'h00020, 0), cmd_pack(OP_WR, 20'h00020, 5), cmd_pack(OP_PRE, 0, 0)};
    check_log("t4");

    // Back-pressure during XFER holds the command stable.
    do_reset();
    send(1'b1, 20'h00100, 6'd7);
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check_eq($sformatf("t5_hold_%0d", i), 32'({cmd_valid, cmd_op, cmd_addr, cmd_len}),
                  32'({1'b1, cmd_pack(OP_WR, 20'h00100, 7)}));
    end
    cmd_ready = 1'b1;
    wait_idle();
    want_q = '{cmd_pack(OP_ACT, 20'h00100, 0), cmd_pack(OP_WR, 20'h00100, 7), cmd_pack(OP_PRE, 0, 0)};
    check_log("t5");

    // Stall across two expiries, then reset in the middle of ACT.
    do_reset();
    cmd_ready = 1'b0;
    send(1'b0, 20'h00200, 6'd0);
    repeat (40) @(posedge clk);
    #1 check_eq("t6_ref_err", 32'(ref_err), 32'(1));
    repeat (3) @(posedge clk);
    #1 check_eq("t6_ref_err_sticky", 32'(ref_err), 32'(1));
    check_eq("t6_mid_act", 32'(cmd_op), 32'(OP_ACT));
    rst = 1'b1;
    @(posedge clk);
    #1 check_eq("t6_rst_outputs", 32'({cmd_valid, cmd_op, cmd_addr, cmd_len, busy, trx_ready, ref_err}), 32'(0));
    rst = 1'b0;
    cmd_ready = 1'b1;

    // Randomized traffic with back-pressure and one mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst          = (i == 1500);
      cmd_ready    = ($urandom_range(0, 3) != 0);
      trx_valid    = $urandom_range(0, 1) != 0;
      trx_is_write = $urandom_range(0, 1) != 0;
      trx_addr     = ($urandom_range(0, 3) == 0) ? (20'hFFFFF - 20'($urandom_range(0, 40))) : 20'($urandom);
      trx_len      = 6'($urandom);
    end
    @(posedge clk);
    #1 begin
      rst = 1'b0; trx_valid = 1'b0; cmd_ready = 1'b1;
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
